thermal_frame_reader: RTL and testbench

Display-side read stage for the thermal frame buffer. Maps each screen coordinate from the display timing generator to a sensor-pixel address on the simple dual-port block RAM's read port, using integer nearest-neighbour upscaling inside a fixed window. Manages ping-pong bank selection so the display never shows a half-written sensor frame. Delivers a pixel stream with sync sideband delayed to match the RAM read latency.

---
 rtl/thermal_frame_reader.sv | 112 +++++++++++
 tb/tb_thermal_frame_reader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/thermal_frame_reader.sv
// rtl/thermal_frame_reader.sv - Display-side frame buffer reader with upscaling and ping-pong bank control
module thermal_frame_reader #(
    parameter int DATA_W = 16,
    parameter int SRC_W  = 32,
    parameter int SRC_H  = 24,
    parameter int SHIFT  = 4,
    parameter int X0     = 64,
    parameter int Y0     = 48,
    parameter int CORDW  = 10,
    parameter int BG     = 0,
    parameter int ADDRW  = $clog2(2*SRC_W*SRC_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CORDW-1:0]  sx,
    input  logic [CORDW-1:0]  sy,
    input  logic              de,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              frame_start,
    input  logic              frame_ready,
    output logic [ADDRW-1:0]  addr_read,
    input  logic [DATA_W-1:0] data_rd,
    output logic              rd_bank,
    output logic              wr_bank,
    output logic [DATA_W-1:0] pix,
    output logic              pix_de,
    output logic              pix_hs,
    output logic              pix_vs,
    output logic              pending
);

    localparam logic [CORDW-1:0]  X0_C      = CORDW'(X0);
    localparam logic [CORDW-1:0]  X1_C      = CORDW'(X0 + (SRC_W << SHIFT));
    localparam logic [CORDW-1:0]  Y0_C      = CORDW'(Y0);
    localparam logic [CORDW-1:0]  Y1_C      = CORDW'(Y0 + (SRC_H << SHIFT));
    localparam logic [ADDRW-1:0]  SRC_W_C   = ADDRW'(SRC_W);
    localparam logic [ADDRW-1:0]  BANK_SZ_C = ADDRW'(SRC_W * SRC_H);
    localparam logic [DATA_W-1:0] BG_C      = DATA_W'(BG);

    logic [ADDRW-1:0]  addr_read_q, addr_read_d;
    logic              rd_bank_q, rd_bank_d;
    logic              pending_q, pending_d;
    logic [3:0]        s1_q, s1_d;   // {in_win, de, hs, vs}
    logic [3:0]        s2_q, s2_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic [2:0]        out_q, out_d; // {de, hs, vs}

    logic             in_win;
    logic [CORDW-1:0] dx, dy;
    logic [ADDRW-1:0] col, row;

    always_comb begin
        in_win = de && (sx >= X0_C) && (sx < X1_C) && (sy >= Y0_C) && (sy < Y1_C);
        dx     = '0;
        dy     = '0;
        if (in_win) begin
            dx = sx - X0_C;
            dy = sy - Y0_C;
        end
        col = ADDRW'(dx >> SHIFT);
        row = ADDRW'(dy >> SHIFT);

        addr_read_d = addr_read_q;
        if (in_win) begin
            addr_read_d = (rd_bank_q ? BANK_SZ_C : '0) + row * SRC_W_C + col;
        end

        // A frame_ready coinciding with frame_start swaps immediately.
        pending_d = pending_q | frame_ready;
        rd_bank_d = rd_bank_q;
        if (frame_start && (pending_q || frame_ready)) begin
            rd_bank_d = ~rd_bank_q;
            pending_d = 1'b0;
        end

        s1_d  = {in_win, de, hsync_in, vsync_in};
        s2_d  = s1_q;
        pix_d = s2_q[3] ? data_rd : BG_C;
        out_d = s2_q[2:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_read_q <= '0;
            rd_bank_q   <= 1'b0;
            pending_q   <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            pix_q       <= BG_C;
            out_q       <= '0;
        end else begin
            addr_read_q <= addr_read_d;
            rd_bank_q   <= rd_bank_d;
            pending_q   <= pending_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            pix_q       <= pix_d;
            out_q       <= out_d;
        end
    end

    assign addr_read = addr_read_q;
    assign rd_bank   = rd_bank_q;
    assign wr_bank   = ~rd_bank_q;
    assign pending   = pending_q;
    assign pix       = pix_q;
    assign pix_de    = out_q[2];
    assign pix_hs    = out_q[1];
    assign pix_vs    = out_q[0];

endmodule

// File: tb/tb_thermal_frame_reader.sv
// tb/tb_thermal_frame_reader.sv - Self-checking bench for thermal_frame_reader
module tb_thermal_frame_reader;

    localparam int DATA_W = 16;
    localparam int CORDW  = 10;
    localparam int ADDRW  = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CORDW-1:0]  sx = '0, sy = '0;
    logic              de = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic              frame_start = 1'b0, frame_ready = 1'b0;
    logic [ADDRW-1:0]  addr_read;
    logic [DATA_W-1:0] data_rd;
    logic              rd_bank, wr_bank, pix_de, pix_hs, pix_vs, pending;
    logic [DATA_W-1:0] pix;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // RAM model preloaded with mem[a] = a, one-cycle read latency.
    always @(posedge clk) data_rd <= DATA_W'(addr_read);

    thermal_frame_reader dut (
        .clk(clk), .rst(rst), .sx(sx), .sy(sy), .de(de),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .frame_start(frame_start), .frame_ready(frame_ready),
        .addr_read(addr_read), .data_rd(data_rd),
        .rd_bank(rd_bank), .wr_bank(wr_bank), .pix(pix),
        .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs), .pending(pending)
    );

    typedef struct {
        int sx;
        int sy;
        int de;
        int exp_addr;
        int exp_pix;
        int exp_de;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{64,  48,  1, 0,   0,   1};
        vecs[1]  = '{79,  48,  1, 0,   0,   1};
        vecs[2]  = '{80,  48,  1, 1,   1,   1};
        vecs[3]  = '{575, 431, 1, 767, 767, 1};
        vecs[4]  = '{63,  48,  1, 767, 0,   1};
        vecs[5]  = '{100, 70,  1, 34,  34,  1};
        vecs[6]  = '{576, 100, 1, 34,  0,   1};
        vecs[7]  = '{100, 70,  0, 34,  0,   0};
        vecs[8]  = '{300, 432, 1, 34,  0,   1};
        vecs[9]  = '{300, 47,  1, 34,  0,   1};
        vecs[10] = '{300, 431, 1, 750, 750, 1};
        vecs[11] = '{100, 70,  0, 750, 0,   0};

        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("reset_pix", int'(pix), 0);
        chk("reset_pix_de", int'(pix_de), 0);
        chk("reset_rd_bank", int'(rd_bank), 0);
        chk("reset_wr_bank", int'(wr_bank), 1);
        chk("reset_pending", int'(pending), 0);
        chk("reset_addr", int'(addr_read), 0);

        for (int i = 0; i < 12; i++) begin
            sx = CORDW'(vecs[i].sx);
            sy = CORDW'(vecs[i].sy);
            de = vecs[i].de[0];
            tick();
            chk($sformatf("vec%0d_addr", i), int'(addr_read), vecs[i].exp_addr);
            tick(); tick();
            chk($sformatf("vec%0d_pix", i), int'(pix), vecs[i].exp_pix);
            chk($sformatf("vec%0d_pix_de", i), int'(pix_de), vecs[i].exp_de);
        end

        // Single-cycle pixel with hsync: exact 3-cycle latency.
        de = 1'b0; hsync_in = 1'b0;
        tick(); tick(); tick();
        sx = 10'd80; sy = 10'd48; de = 1'b1; hsync_in = 1'b1;
        tick();
        de = 1'b0; hsync_in = 1'b0;
        chk("lat_addr_n1", int'(addr_read), 1);
        chk("lat_de_n1", int'(pix_de), 0);
        tick();
        chk("lat_de_n2", int'(pix_de), 0);
        tick();
        chk("lat_de_n3", int'(pix_de), 1);
        chk("lat_hs_n3", int'(pix_hs), 1);
        chk("lat_pix_n3", int'(pix), 1);
        tick();
        chk("lat_de_n4", int'(pix_de), 0);
        chk("lat_pix_n4", int'(pix), 0);

        // Bank swap via pending.
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        chk("swap_pending_set", int'(pending), 1);
        chk("swap_rd_before", int'(rd_bank), 0);
        tick();
        chk("swap_pending_hold", int'(pending), 1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("swap_rd_bank", int'(rd_bank), 1);
        chk("swap_wr_bank", int'(wr_bank), 0);
        chk("swap_pending_clr", int'(pending), 0);
        sx = 10'd64; sy = 10'd48; de = 1'b1;
        tick();
        chk("bank1_addr", int'(addr_read), 768);
        tick(); tick();
        chk("bank1_pix", int'(pix), 768);
        de = 1'b0;

        // frame_start without pending: no swap.
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("nopend_rd_bank", int'(rd_bank), 1);

        // Simultaneous frame_ready and frame_start.
        frame_ready = 1'b1; frame_start = 1'b1; tick();
        frame_ready = 1'b0; frame_start = 1'b0;
        chk("simul_rd_bank", int'(rd_bank), 0);
        chk("simul_pending", int'(pending), 0);

        // Two frame_ready pulses, one frame_start: single toggle.
        frame_ready = 1'b1; tick(); frame_ready = 1'b0; tick();
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        chk("double_pending", int'(pending), 1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("double_rd_bank", int'(rd_bank), 1);
        chk("double_pending_clr", int'(pending), 0);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("double_no_second", int'(rd_bank), 1);

        // Async reset mid-line with rd_bank=1 and pending set.
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        sx = 10'd200; sy = 10'd100; de = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_pix_de", int'(pix_de), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_rd_bank", int'(rd_bank), 0);
        chk("arst_wr_bank", int'(wr_bank), 1);
        chk("arst_pending", int'(pending), 0);
        chk("arst_addr", int'(addr_read), 0);
        chk("arst_pix", int'(pix), 0);
        chk("arst_pix_de", int'(pix_de), 0);
        chk("arst_pix_hs", int'(pix_hs), 0);
        chk("arst_pix_vs", int'(pix_vs), 0);
        tick();
        rst = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        sx = 10'd80; sy = 10'd64; de = 1'b1;
        tick();
        chk("post_rst_addr", int'(addr_read), 33);
        chk("post_rst_de_n1", int'(pix_de), 0);
        tick();
        chk("post_rst_de_n2", int'(pix_de), 0);
        tick();
        chk("post_rst_pix", int'(pix), 33);
        chk("post_rst_de_n3", int'(pix_de), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
